// File: rtl/trigger_array_pkg.sv
// Shared types for the trigger family: FSM states, coarse modes and HLS actor return codes.
// Return codes are 32-bit; consuming modules resize them to their RET_W.
package TriggerTypes;

    typedef enum logic [3:0] {
        IDLE_STATE  = 4'd0,
        LAUNCH      = 4'd1,
        CHECK       = 4'd2,
        SLEEP       = 4'd3,
        SYNC_LAUNCH = 4'd4,
        SYNC_CHECK  = 4'd5,
        SYNC_WAIT   = 4'd6,
        SYNC_EXEC   = 4'd7
    } state_t;

    typedef enum logic [1:0] {
        MODE_IDLE  = 2'd0,
        MODE_RUN   = 2'd1,
        MODE_SLEEP = 2'd2,
        MODE_SYNC  = 2'd3
    } mode_t;

    localparam logic [31:0] RET_IDLE    = 32'd0;
    localparam logic [31:0] EXECUTED    = 32'd1;
    localparam logic [31:0] TEST_FAILED = 32'd2;
    localparam logic [31:0] WAIT_INPUT  = 32'd3;
    localparam logic [31:0] WAIT_OUTPUT = 32'd4;

    function automatic mode_t state_mode(input state_t s);
        mode_t m;
        case (s)
            LAUNCH, CHECK:                               m = MODE_RUN;
            SLEEP:                                       m = MODE_SLEEP;
            SYNC_LAUNCH, SYNC_CHECK, SYNC_WAIT, SYNC_EXEC: m = MODE_SYNC;
            default:                                     m = MODE_IDLE;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/trigger_array_fsm.sv
// One actor scheduling FSM with its bounded retry counter. All outputs are
// registered, decoded from the next state so they track the state register exactly.
module trigger_fsm
    import TriggerTypes::*;
#(
    parameter int RET_W       = 32,
    parameter int RETRY_LIMIT = 0,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ap_start,
    input  logic             ap_idle,
    input  logic             all_sleep,
    input  logic             all_sync,
    input  logic             all_sync_wait,
    input  logic             external_enqueue,
    input  logic [RET_W-1:0] actor_return,
    input  logic             actor_done,
    output logic             actor_start,
    output logic             sleep,
    output logic             sync_wait,
    output logic             sync_exec,
    output logic             idle
);

    localparam logic [RET_W-1:0] EXEC_C  = RET_W'(EXECUTED);
    localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(RETRY_LIMIT);

    state_t             state_r;
    state_t             state_s;
    logic [CNT_W-1:0]   retry_r;
    logic [CNT_W-1:0]   retry_s;
    logic               is_exec_s;

    assign is_exec_s = (actor_return == EXEC_C);

    // Next-state and retry-counter logic
    always_comb begin
        state_s = state_r;
        retry_s = retry_r;
        case (state_r)
            IDLE_STATE: begin
                if (ap_start && ap_idle) state_s = LAUNCH;
                else                     state_s = IDLE_STATE;
            end
            LAUNCH, CHECK: begin
                if (!actor_done) begin
                    state_s = CHECK;
                end else if (is_exec_s || external_enqueue) begin
                    state_s = LAUNCH;
                    retry_s = {CNT_W{1'b0}};
                end else if (retry_r != LIMIT_C) begin
                    // retry_r never exceeds LIMIT_C, so != is the "below limit" test
                    state_s = LAUNCH;
                    retry_s = retry_r + CNT_W'(1);
                end else begin
                    state_s = SLEEP;
                    retry_s = {CNT_W{1'b0}};
                end
            end
            SLEEP: begin
                if (all_sleep)             state_s = SYNC_LAUNCH;
                else if (external_enqueue) state_s = LAUNCH;
                else                       state_s = SLEEP;
            end
            SYNC_LAUNCH, SYNC_CHECK: begin
                if (!actor_done)    state_s = SYNC_CHECK;
                else if (is_exec_s) state_s = SYNC_EXEC;
                else                state_s = SYNC_WAIT;
            end
            SYNC_WAIT: begin
                if (all_sync && all_sync_wait) state_s = IDLE_STATE;
                else if (all_sync)             state_s = LAUNCH;
                else                           state_s = SYNC_WAIT;
            end
            SYNC_EXEC: begin
                if (all_sync) state_s = LAUNCH;
                else          state_s = SYNC_EXEC;
            end
            default: begin
                state_s = IDLE_STATE;
                retry_s = {CNT_W{1'b0}};
            end
        endcase
    end

    // State, retry counter and decoded status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE_STATE;
            retry_r     <= {CNT_W{1'b0}};
            actor_start <= 1'b0;
            sleep       <= 1'b0;
            sync_wait   <= 1'b0;
            sync_exec   <= 1'b0;
            idle        <= 1'b1;
        end else begin
            state_r     <= state_s;
            retry_r     <= retry_s;
            actor_start <= (state_s == LAUNCH) || (state_s == SYNC_LAUNCH);
            sleep       <= (state_mode(state_s) == MODE_SLEEP);
            sync_wait   <= (state_s == SYNC_WAIT);
            sync_exec   <= (state_s == SYNC_EXEC);
            idle        <= (state_mode(state_s) == MODE_IDLE);
        end
    end

endmodule

// File: rtl/trigger_array.sv
// Schedules NUM_ACTORS HLS actors from one ap_start/ap_done handshake with shared sleep/sync votes.
// Optional profiling counters (fire_count, sync_rounds) are built when TRIGGER_ARRAY_PROFILE_EN is defined.
module trigger_array
    import TriggerTypes::*;
#(
    parameter int NUM_ACTORS  = 4,
    parameter int RET_W       = 32,
    parameter int RETRY_LIMIT = 0,
    parameter int CNT_W       = 8
) (
    input  logic                        ap_clk,
    input  logic                        ap_rst_n,
    input  logic                        ap_start,
    output logic                        ap_done,
    output logic                        ap_ready,
    output logic                        ap_idle,
    input  logic [NUM_ACTORS-1:0]       external_enqueue,
    input  logic [NUM_ACTORS*RET_W-1:0] actor_return,
    input  logic [NUM_ACTORS-1:0]       actor_done,
    input  logic [NUM_ACTORS-1:0]       actor_ready,
    input  logic [NUM_ACTORS-1:0]       actor_idle,
    output logic [NUM_ACTORS-1:0]       actor_start,
    output logic [NUM_ACTORS-1:0]       sleep_vec,
    output logic [NUM_ACTORS-1:0]       sync_vec
`ifdef TRIGGER_ARRAY_PROFILE_EN
    ,
    output logic [NUM_ACTORS*32-1:0]    fire_count,
    output logic [15:0]                 sync_rounds
`endif
);

    logic [NUM_ACTORS-1:0] wait_vec_s;
    logic [NUM_ACTORS-1:0] exec_vec_s;
    logic [NUM_ACTORS-1:0] idle_vec_s;
    logic                  all_sleep_s;
    logic                  all_sync_s;
    logic                  all_sync_wait_s;
    logic                  unused_inputs_s;

    assign unused_inputs_s = ^{actor_ready, actor_idle};

    assign all_sleep_s     = &sleep_vec;
    assign all_sync_s      = &(wait_vec_s | exec_vec_s);
    assign all_sync_wait_s = &wait_vec_s;
    assign sync_vec        = wait_vec_s | exec_vec_s;
    assign ap_idle         = &idle_vec_s;
    // Every actor sits in SYNC_WAIT for exactly one cycle before the joint return to idle
    assign ap_done         = all_sync_wait_s;
    assign ap_ready        = all_sync_wait_s;

    for (genvar i = 0; i < NUM_ACTORS; i++) begin : g_actor
        trigger_fsm #(
            .RET_W       (RET_W),
            .RETRY_LIMIT (RETRY_LIMIT),
            .CNT_W       (CNT_W)
        ) u_fsm (
            .clk              (ap_clk),
            .rst_n            (ap_rst_n),
            .ap_start         (ap_start),
            .ap_idle          (ap_idle),
            .all_sleep        (all_sleep_s),
            .all_sync         (all_sync_s),
            .all_sync_wait    (all_sync_wait_s),
            .external_enqueue (external_enqueue[i]),
            .actor_return     (actor_return[i*RET_W +: RET_W]),
            .actor_done       (actor_done[i]),
            .actor_start      (actor_start[i]),
            .sleep            (sleep_vec[i]),
            .sync_wait        (wait_vec_s[i]),
            .sync_exec        (exec_vec_s[i]),
            .idle             (idle_vec_s[i])
        );
    end

`ifdef TRIGGER_ARRAY_PROFILE_EN
    localparam logic [RET_W-1:0] EXEC_C = RET_W'(EXECUTED);

    logic        start_accept_s;
    logic [31:0] fire_cnt_r [NUM_ACTORS];

    assign start_accept_s = ap_start && ap_idle;

    for (genvar i = 0; i < NUM_ACTORS; i++) begin : g_prof
        // Saturating per-actor count of EXECUTED completions in the current run
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                fire_cnt_r[i] <= 32'd0;
            end else if (start_accept_s) begin
                fire_cnt_r[i] <= 32'd0;
            end else if (actor_done[i] && (actor_return[i*RET_W +: RET_W] == EXEC_C)
                         && (fire_cnt_r[i] != 32'hFFFF_FFFF)) begin
                fire_cnt_r[i] <= fire_cnt_r[i] + 32'd1;
            end else begin
                fire_cnt_r[i] <= fire_cnt_r[i];
            end
        end
        assign fire_count[i*32 +: 32] = fire_cnt_r[i];
    end

    // all_sleep is the single cycle in which every actor enters SYNC_LAUNCH
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sync_rounds <= 16'd0;
        end else if (start_accept_s) begin
            sync_rounds <= 16'd0;
        end else if (all_sleep_s && (sync_rounds != 16'hFFFF)) begin
            sync_rounds <= sync_rounds + 16'd1;
        end else begin
            sync_rounds <= sync_rounds;
        end
    end
`endif

endmodule

// File: tb/tb_trigger_array.sv
// Directed bench for trigger_array: two 2-actor instances (RETRY_LIMIT 0 and 2) driven by
// a simple actor model that answers each actor_start with actor_done one cycle later.
module tb_trigger_array;

    localparam logic [31:0] R_EXEC = 32'd1;
    localparam logic [31:0] R_WAIT = 32'd3;

    logic        clk;
    logic        rst_n;
    logic        apstart  [2];
    logic        apdone   [2];
    logic        apready  [2];
    logic        apidle   [2];
    logic [1:0]  ext      [2];
    logic [63:0] aret     [2];
    logic [1:0]  adone    [2];
    logic [1:0]  astart   [2];
    logic [1:0]  sleepv   [2];
    logic [1:0]  syncv    [2];
`ifdef TRIGGER_ARRAY_PROFILE_EN
    logic [63:0] fc       [2];
    logic [15:0] sr       [2];
`endif

    int          exec_left [2][2];
    logic [1:0]  pend      [2];
    int          starts    [2][2];
    int          n_tests;
    int          n_fail;
    logic        seen;

    trigger_array #(.NUM_ACTORS(2), .RET_W(32), .RETRY_LIMIT(0), .CNT_W(8)) dut_a (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(apstart[0]), .ap_done(apdone[0]),
        .ap_ready(apready[0]), .ap_idle(apidle[0]), .external_enqueue(ext[0]),
        .actor_return(aret[0]), .actor_done(adone[0]), .actor_ready(2'b00),
        .actor_idle(2'b00), .actor_start(astart[0]), .sleep_vec(sleepv[0]), .sync_vec(syncv[0])
`ifdef TRIGGER_ARRAY_PROFILE_EN
        , .fire_count(fc[0]), .sync_rounds(sr[0])
`endif
    );

    trigger_array #(.NUM_ACTORS(2), .RET_W(32), .RETRY_LIMIT(2), .CNT_W(8)) dut_b (
        .ap_clk(clk), .ap_rst_n(rst_n), .ap_start(apstart[1]), .ap_done(apdone[1]),
        .ap_ready(apready[1]), .ap_idle(apidle[1]), .external_enqueue(ext[1]),
        .actor_return(aret[1]), .actor_done(adone[1]), .actor_ready(2'b00),
        .actor_idle(2'b00), .actor_start(astart[1]), .sleep_vec(sleepv[1]), .sync_vec(syncv[1])
`ifdef TRIGGER_ARRAY_PROFILE_EN
        , .fire_count(fc[1]), .sync_rounds(sr[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock: sample after the edge, then play the actor model for both instances
    task automatic step();
        @(posedge clk);
        #1;
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < 2; i++) begin
                adone[d][i] = pend[d][i];
                if (pend[d][i] && exec_left[d][i] > 0) begin
                    aret[d][i*32 +: 32] = R_EXEC;
                    exec_left[d][i]--;
                end else if (pend[d][i]) begin
                    aret[d][i*32 +: 32] = R_WAIT;
                end else begin
                    aret[d][i*32 +: 32] = 32'd0;
                end
                pend[d][i] = astart[d][i];
                if (astart[d][i]) starts[d][i]++;
            end
        end
    endtask

    task automatic kick(input int d);
        for (int i = 0; i < 2; i++) starts[d][i] = 0;
        apstart[d] = 1'b1;
        step();
        apstart[d] = 1'b0;
    endtask

    task automatic finish_run(input int d, input string tag);
        for (int k = 0; k < 200 && !apdone[d]; k++) step();
        check({tag, "_done"}, {63'd0, apdone[d]}, 64'd1);
        check({tag, "_ready"}, {63'd0, apready[d]}, 64'd1);
        check({tag, "_syncwait"}, {62'd0, syncv[d]}, 64'd3);
        step();
        check({tag, "_done_pulse"}, {63'd0, apdone[d]}, 64'd0);
        check({tag, "_idle_after"}, {63'd0, apidle[d]}, 64'd1);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        for (int d = 0; d < 2; d++) begin
            apstart[d] = 1'b0;
            ext[d]     = 2'b00;
            aret[d]    = 64'd0;
            adone[d]   = 2'b00;
            pend[d]    = 2'b00;
            for (int i = 0; i < 2; i++) begin
                exec_left[d][i] = 0;
                starts[d][i]    = 0;
            end
        end
        repeat (3) step();
        check("rst_idle", {63'd0, apidle[0]}, 64'd1);
        check("rst_start", {62'd0, astart[0]}, 64'd0);
        check("rst_done", {63'd0, apdone[0]}, 64'd0);
        check("rst_vecs", {60'd0, sleepv[0], syncv[0]}, 64'd0);
        rst_n = 1'b1;
        step();

        // Run with three EXECUTED firings per actor, then sleep, sync and finish
        exec_left[0][0] = 3;
        exec_left[0][1] = 3;
        kick(0);
        check("t1_launch", {62'd0, astart[0]}, 64'd3);
        check("t1_busy", {63'd0, apidle[0]}, 64'd0);
        for (int k = 0; k < 100 && sleepv[0] != 2'b11; k++) step();
        check("t1_sleep", {62'd0, sleepv[0]}, 64'd3);
        check("t1_starts_pre", 64'(starts[0][0]), 64'd4);
        step();
        check("t1_sync_launch", {62'd0, astart[0]}, 64'd3);
        finish_run(0, "t1");
        check("t1_starts_total", 64'(starts[0][1]), 64'd5);

        // Bounded retry: two extra relaunches before SLEEP
        kick(1);
        for (int k = 0; k < 100 && !sleepv[1][0]; k++) step();
        check("t2_sleep", {63'd0, sleepv[1][0]}, 64'd1);
        check("t2_starts", 64'(starts[1][0]), 64'd3);
        check("t2_retry", {56'd0, dut_b.g_actor[0].u_fsm.retry_r}, 64'd0);
        finish_run(1, "t2");

        // Wake actor0 from SLEEP by enqueue while actor1 keeps firing
        exec_left[0][0] = 0;
        exec_left[0][1] = 1000;
        kick(0);
        for (int k = 0; k < 100 && !sleepv[0][0]; k++) step();
        repeat (3) step();
        check("t3_still_sleep", {63'd0, sleepv[0][0]}, 64'd1);
        check("t3_busy", {63'd0, apidle[0]}, 64'd0);
        ext[0] = 2'b01;
        step();
        ext[0] = 2'b00;
        check("t3_wake_start", {63'd0, astart[0][0]}, 64'd1);
        check("t3_wake_sleep", {63'd0, sleepv[0][0]}, 64'd0);
        step();

        // Mixed sync round: actor0 EXECUTED, actor1 not -> both relaunch, no done
        exec_left[0][0] = 1;
        exec_left[0][1] = 0;
        seen = 1'b0;
        for (int k = 0; k < 100 && syncv[0] != 2'b11; k++) begin
            step();
            if (apdone[0]) seen = 1'b1;
        end
        check("t4_all_sync", {62'd0, syncv[0]}, 64'd3);
        check("t4_no_done", {63'd0, seen | apdone[0]}, 64'd0);
        step();
        check("t4_relaunch", {62'd0, astart[0]}, 64'd3);
        check("t4_left_sync", {62'd0, syncv[0]}, 64'd0);
        finish_run(0, "t4");

        // Asynchronous reset in the middle of CHECK
        exec_left[0][0] = 1000;
        exec_left[0][1] = 1000;
        kick(0);
        step();
        check("t5_busy", {63'd0, apidle[0]}, 64'd0);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_idle", {63'd0, apidle[0]}, 64'd1);
        check("t5_rst_start", {62'd0, astart[0]}, 64'd0);
        exec_left[0][0] = 0;
        exec_left[0][1] = 0;
        pend[0]  = 2'b00;
        adone[0] = 2'b00;
        aret[0]  = 64'd0;
        step();
        step();
        rst_n = 1'b1;
        seen  = 1'b0;
        for (int k = 0; k < 20; k++) begin
            step();
            if (apdone[0] || !apidle[0]) seen = 1'b1;
        end
        check("t5_quiet_after", {63'd0, seen}, 64'd0);

`ifdef TRIGGER_ARRAY_PROFILE_EN
        // Profile counters: five EXECUTED firings on actor1, cleared on next accepted start
        exec_left[0][1] = 5;
        kick(0);
        finish_run(0, "t6");
        check("t6_fire1", {32'd0, fc[0][63:32]}, 64'd5);
        check("t6_fire0", {32'd0, fc[0][31:0]}, 64'd0);
        check("t6_rounds", {48'd0, sr[0]}, 64'd1);
        kick(0);
        check("t6_clear", fc[0], 64'd0);
        finish_run(0, "t6b");
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/trigger_array.md
Name: trigger_array

Overview:
- Parametrised successor to the single-actor trigger.
- Schedules NUM_ACTORS HLS actors from one ap_start/ap_done handshake.
- Aggregates the sleep/sync votes internally, so the network-level top no longer wires all_sleep/all_sync/all_sync_wait by hand.
- Adds a bounded retry before sleeping, and enqueue-driven wake-up from SLEEP.

Parameters:
- NUM_ACTORS, 4, number of controlled actors (1..64).
- RET_W, 32, width of each actor return code.
- RETRY_LIMIT, 0, extra relaunches after a non-EXECUTED return before entering SLEEP (0 = legacy behaviour).
- CNT_W, 8, width of the per-actor retry counter; must satisfy RETRY_LIMIT < 2^CNT_W.

Ports:
- ap_clk  in  1  single clock, rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- ap_start  in  1  start a network run; sampled only while ap_idle=1.
- ap_done  out  1  one-cycle pulse at end of run.
- ap_ready  out  1  equal to ap_done.
- ap_idle  out  1  all actor FSMs in IDLE_STATE.
- external_enqueue  in  NUM_ACTORS  per-actor external buffer enqueue.
- actor_return  in  NUM_ACTORS*RET_W  packed return codes; actor i at bits [i*RET_W +: RET_W].
- actor_done  in  NUM_ACTORS  per-actor ap_done.
- actor_ready  in  NUM_ACTORS  per-actor ap_ready; unused, kept for interface symmetry.
- actor_idle  in  NUM_ACTORS  per-actor ap_idle; unused.
- actor_start  out  NUM_ACTORS  per-actor ap_start.
- sleep_vec  out  NUM_ACTORS  actor i in SLEEP.
- sync_vec  out  NUM_ACTORS  actor i in SYNC_WAIT or SYNC_EXEC.

Behaviour:
- Reset (async assert, sync release): all FSMs go to IDLE_STATE and retry counters clear.
  - Outputs during reset: ap_done=0, ap_ready=0, ap_idle=1, actor_start=0, sleep_vec=0, sync_vec=0.
  - Reset mid-run abandons the run; no ap_done is generated.
- Aggregate votes, combinational from registered state:
  - all_sleep = &sleep.
  - all_sync = &(sync_wait|sync_exec).
  - all_sync_wait = &sync_wait.
- Per-actor FSM, states from the shared state_t:
  - IDLE_STATE: ap_start & ap_idle -> LAUNCH, for every actor in the same cycle. ap_start while not idle is ignored.
  - LAUNCH, CHECK, actor_done=0: -> CHECK.
  - LAUNCH, CHECK, actor_done=1:
    - return==EXECUTED or external_enqueue[i] -> LAUNCH, and the retry counter clears.
    - else retry<RETRY_LIMIT -> LAUNCH, and retry increments.
    - else -> SLEEP, and retry clears.
  - SLEEP:
    - all_sleep -> SYNC_LAUNCH. This has priority.
    - else external_enqueue[i] -> LAUNCH (new wake-up path).
    - else stay in SLEEP.
  - SYNC_LAUNCH, SYNC_CHECK, done with EXECUTED -> SYNC_EXEC.
  - SYNC_LAUNCH, SYNC_CHECK, done with any other return -> SYNC_WAIT.
  - SYNC_LAUNCH, SYNC_CHECK, not done -> SYNC_CHECK.
  - In sync states, external_enqueue is ignored and no retry is applied.
  - SYNC_WAIT: all_sync & all_sync_wait -> IDLE_STATE; all_sync & ~all_sync_wait -> LAUNCH; else stay.
  - SYNC_EXEC: all_sync -> LAUNCH; else stay.
  - Any unencoded state -> IDLE_STATE.
- actor_start[i] = state is LAUNCH or SYNC_LAUNCH (Moore; one-cycle pulse per launch).
- ap_done is combinational: asserted exactly in the cycle when all actors sit in SYNC_WAIT, before they move to IDLE_STATE together on the next edge. ap_ready = ap_done.
- Because SYNC_WAIT exits are decided by shared votes, all actors leave sync states in the same cycle.
- NUM_ACTORS=1 with RETRY_LIMIT=0 is cycle-identical to the legacy single trigger, except for the SLEEP wake path.

Optional Feature:
- Macro: TRIGGER_ARRAY_PROFILE_EN.
- Defined:
  - Adds output port fire_count, width NUM_ACTORS*32.
  - Per actor, a counter increments on each actor_done with return==EXECUTED.
  - Counters clear on reset and on ap_start acceptance, and saturate at 2^32-1.
  - Also adds output port sync_rounds, 16 bits: the count of SYNC_LAUNCH entries in the current run, saturating.
- Undefined: neither port exists, and there is no counter logic.

Decomposition:
- Shared package TriggerTypes, extended with:
  - state_t;
  - mode_t;
  - EXECUTED and the other return-code constants, sized to RET_W via a localparam in the consuming modules.
- Sub-module trigger_fsm: one actor FSM plus its retry counter. It takes the aggregate votes as inputs and emits sleep/sync_wait/sync_exec/actor_start.
- trigger_array instantiates NUM_ACTORS copies in a generate loop, computes the reductions, and drives the ap_* handshake.

Test Plan:
- NUM_ACTORS=2, RETRY_LIMIT=0. Both actors return EXECUTED 3 times, then non-EXECUTED with done 1 cycle after start -> both reach SLEEP, then SYNC_LAUNCH, both return non-EXECUTED -> SYNC_WAIT; ap_done high for 1 cycle; ap_idle=1 next cycle.
- RETRY_LIMIT=2, actor0 returns non-EXECUTED forever -> exactly 3 actor_start pulses before SLEEP; retry counter back at 0.
- Actor0 in SLEEP, actor1 running; pulse external_enqueue[0] for 1 cycle -> actor0 in LAUNCH next cycle, actor_start[0]=1.
- Sync round with actor0 EXECUTED and actor1 non-EXECUTED -> both in LAUNCH the cycle after all_sync; no ap_done.
- Assert ap_rst_n=0 asynchronously mid-CHECK -> actor_start=0 and ap_idle=1 immediately; no ap_done after release.
- With TRIGGER_ARRAY_PROFILE_EN: 5 EXECUTED firings on actor1 -> fire_count[63:32]=5; cleared to 0 on next accepted ap_start.
